// File: rtl/data_memory_responder_if.sv
// Request/response bus between a load/store initiator and the
// data memory responder.
interface data_memory_responder_if;
    logic        request;
    logic        write_enable;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic        ready;
    logic [31:0] read_data;
    logic        error;

    modport master (
        output request, write_enable, address, write_data, byte_enable,
        input  ready, read_data, error
    );

    modport slave (
        input  request, write_enable, address, write_data, byte_enable,
        output ready, read_data, error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data memory with programmable wait states,
// byte-masked writes and alignment/range fault reporting.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input logic clk,
    input logic reset,
    data_memory_responder_if.slave bus
);
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam logic [29:0] DEPTH = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t state;
    state_t state_nx;
    logic [3:0] cnt;

    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    logic          fault;
    logic [IW-1:0] idx;
    logic [31:0]   mem [DEPTH_WORDS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE:  cnt <= bus.request ? WS : '0;
                S_WAIT:  cnt <= cnt - 4'd1;
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (bus.request)
                    state_nx = (WS == 4'd0) ? S_RESPOND : S_WAIT;
            end
            S_WAIT: begin
                if (!bus.request)
                    state_nx = S_IDLE;
                else if (cnt == 4'd1)
                    state_nx = S_RESPOND;
            end
            S_RESPOND: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Access fields are frozen at capture so later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
        end else if (state == S_IDLE && bus.request) begin
            cap_we    <= bus.write_enable;
            cap_addr  <= bus.address;
            cap_wdata <= bus.write_data;
            cap_be    <= bus.byte_enable;
        end
    end

    assign fault = (cap_addr[1:0] != 2'b00) || (cap_addr[31:2] >= DEPTH);
    assign idx   = cap_addr[IW+1:2];

    always_comb begin
        bus.ready     = 1'b0;
        bus.error     = 1'b0;
        bus.read_data = '0;
        if (state == S_RESPOND) begin
            bus.ready     = 1'b1;
            bus.error     = fault;
            bus.read_data = fault ? '0 : mem[idx];
        end
    end

    // Storage is not reset; the write lands on the edge that ends RESPOND.
    always_ff @(posedge clk) begin
        if (state == S_RESPOND && cap_we && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (cap_be[b])
                    mem[idx][8*b +: 8] <= cap_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized scoreboard bench for data_memory_responder against a
// word-array reference model.
module tb_data_memory_responder;
    localparam int WS    = 2;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    data_memory_responder_if bus ();
    data_memory_responder_if bus0 ();

    data_memory_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    data_memory_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(0)
    ) dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0)
    );

    typedef struct {
        int          due;
        bit          chk_data;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          ncnt     = 0;
    logic [31:0] model[DEPTH];

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        ncnt++;
        if (bus.ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("latency", 32'(ncnt), 32'(e.due));
                chk("error", 32'(bus.error), 32'(e.err));
                if (e.chk_data)
                    chk("read_data", bus.read_data, e.data);
            end
        end else begin
            chk("idle_error", 32'(bus.error), 32'd0);
            chk("idle_rdata", bus.read_data, 32'd0);
        end
    end

    // mode: 0 normal, 1 abort in WAIT, 2 reset in WAIT, 3 reset in RESPOND
    task automatic access(input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input int mode);
        exp_t e;
        bit   flt;
        flt = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
        bus.request      = 1'b1;
        bus.write_enable = we;
        bus.address      = a;
        bus.write_data   = wd;
        bus.byte_enable  = be;
        @(posedge clk);
        e.due = ncnt + WS + 1;
        #1;
        bus.write_enable = 1'($urandom);
        bus.address      = $urandom;
        bus.write_data   = $urandom;
        bus.byte_enable  = 4'($urandom);
        if (mode == 1) begin
            bus.request = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        if (mode == 2 || mode == 3) begin
            if (mode == 3) begin
                repeat (WS) @(posedge clk);
                #1;
            end
            #1 reset = 1'b0;
            bus.request = 1'b0;
            #1;
            chk("reset_abort_ready", 32'(bus.ready), 32'd0);
            chk("reset_abort_rdata", bus.read_data, 32'd0);
            @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            #1;
            return;
        end
        e.err      = flt;
        e.chk_data = !we;
        e.data     = '0;
        if (!flt && !we)
            e.data = model[a[31:2]];
        if (!flt && we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model[a[31:2]][8*b +: 8] = wd[8*b +: 8];
        end
        sb.push_back(e);
        repeat (WS) @(posedge clk);
        #1;
        // Holding request through RESPOND must not start a new access.
        if ($urandom_range(1) == 1) begin
            bus.request      = 1'b1;
            bus.write_enable = 1'($urandom);
            bus.address      = $urandom;
            bus.write_data   = $urandom;
            bus.byte_enable  = 4'($urandom);
        end else begin
            bus.request = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.request = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)
            return 32'($urandom_range(0, DEPTH + 7)) << 2;
        else if (r == 7)
            return (32'($urandom_range(0, DEPTH - 1)) << 2)
                   | 32'($urandom_range(1, 3));
        else
            return $urandom;
    endfunction

    initial begin
        int m;
        bus.request       = 1'b0;
        bus.write_enable  = 1'b0;
        bus.address       = '0;
        bus.write_data    = '0;
        bus.byte_enable   = '0;
        bus0.request      = 1'b0;
        bus0.write_enable = 1'b0;
        bus0.address      = '0;
        bus0.write_data   = '0;
        bus0.byte_enable  = '0;

        #2 reset = 1'b0;
        #1;
        chk("reset_ready", 32'(bus.ready), 32'd0);
        chk("reset_error", 32'(bus.error), 32'd0);
        chk("reset_rdata", bus.read_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            access(1'b1, 32'(i) << 2, $urandom, 4'hF, 0);

        access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        access(1'b0, 32'h10, 32'h0, 4'hF, 0);
        access(1'b1, 32'h20, 32'h11223344, 4'hF, 0);
        access(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
        access(1'b0, 32'h20, 32'h0, 4'hF, 0);
        access(1'b0, 32'h13, 32'h0, 4'hF, 0);
        access(1'b0, 32'h100, 32'h0, 4'hF, 0);
        access(1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 0);
        access(1'b1, 32'h04, 32'h01234567, 4'hF, 1);
        access(1'b0, 32'h04, 32'h0, 4'hF, 0);
        access(1'b1, 32'h08, 32'h89ABCDEF, 4'hF, 2);
        access(1'b0, 32'h08, 32'h0, 4'hF, 0);
        access(1'b1, 32'h0C, 32'h55AA55AA, 4'hF, 3);
        access(1'b0, 32'h0C, 32'h0, 4'hF, 0);
        access(1'b1, 32'h14, 32'hFFFFFFFF, 4'b0000, 0);
        access(1'b0, 32'h14, 32'h0, 4'hF, 0);

        repeat (300) begin
            m = $urandom_range(0, 19);
            access(1'($urandom), rand_addr(), $urandom, 4'($urandom),
                   (m < 3) ? m + 1 : 0);
        end

        for (int i = 0; i < DEPTH; i++)
            access(1'b0, 32'(i) << 2, 32'h0, 4'hF, 0);

        // Zero wait states: ready on the cycle right after capture.
        bus0.request      = 1'b1;
        bus0.write_enable = 1'b1;
        bus0.address      = 32'h0;
        bus0.write_data   = 32'h5;
        bus0.byte_enable  = 4'hF;
        @(posedge clk);
        #1;
        bus0.request    = 1'b0;
        bus0.write_data = 32'hFFFF0000;
        @(negedge clk);
        chk("zl_write_ready", 32'(bus0.ready), 32'd1);
        chk("zl_write_error", 32'(bus0.error), 32'd0);
        @(posedge clk);
        #1;
        bus0.request      = 1'b1;
        bus0.write_enable = 1'b0;
        @(posedge clk);
        #1;
        bus0.request = 1'b0;
        @(negedge clk);
        chk("zl_read_ready", 32'(bus0.ready), 32'd1);
        chk("zl_read_data", bus0.read_data, 32'h5);
        chk("zl_read_error", 32'(bus0.error), 32'd0);
        @(negedge clk);
        chk("zl_ready_one_cycle", 32'(bus0.ready), 32'd0);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, meaning the number of 32-bit words stored.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, meaning the idle cycles inserted between request capture and response (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port request, input, 1, initiator asserts to start an access.
REQ-006 The block SHALL have port write_enable, input, 1, 1 = write access, 0 = read access.
REQ-007 The block SHALL have port address, input, 32, byte address of the access.
REQ-008 The block SHALL have port write_data, input, 32, store data.
REQ-009 The block SHALL have port byte_enable, input, 4, per-byte write mask; bit i covers write_data[8i+7:8i].
REQ-010 The block SHALL have port ready, output, 1, one-cycle response strobe.
REQ-011 The block SHALL have port read_data, output, 32, load data, valid only while ready=1.
REQ-012 The block SHALL have port error, output, 1, access fault flag, valid only while ready=1.

Function
REQ-013 The block SHALL implement three states: IDLE, WAIT, RESPOND.
REQ-014 In IDLE with request=1, the block SHALL capture write_enable, address, write_data and byte_enable, then go to WAIT (WAIT_STATES>0) or to RESPOND (WAIT_STATES=0).
REQ-015 In WAIT, a down-counter loaded with WAIT_STATES SHALL decrement once per cycle; at count 1, the next state SHALL be RESPOND.
REQ-016 If request drops to 0 during WAIT, the block SHALL abort to IDLE with no memory update and no ready pulse.
REQ-017 In RESPOND, ready SHALL be 1 for exactly one cycle, followed by an unconditional return to IDLE.
REQ-018 Request-to-ready latency SHALL be WAIT_STATES+1 cycles from the capturing edge.
REQ-019 Inputs changing after capture SHALL NOT affect the access in flight.
REQ-020 Fault condition: captured address[1:0] != 0, or word index address[31:2] >= DEPTH_WORDS.
REQ-021 On fault, error=1 and read_data=0 in RESPOND, and memory SHALL NOT be modified.
REQ-022 On a non-faulting write, only the bytes whose byte_enable bit is set SHALL be updated, at the clock edge that ends RESPOND.
REQ-023 On a non-faulting read, read_data SHALL equal the stored word at the captured index; error=0.
REQ-024 A write with byte_enable=0000 SHALL complete normally with no change to memory.
REQ-025 Outside RESPOND, ready, error and read_data SHALL be 0.
REQ-026 request held high in the RESPOND cycle SHALL NOT be captured; a new access starts only from IDLE, giving a minimum of WAIT_STATES+2 cycles between back-to-back requests.

Reset
REQ-027 With reset=0, the block SHALL immediately enter IDLE, clear the counter, and force ready=0, error=0 and read_data=0, independent of clk.
REQ-028 Reset asserted mid-access SHALL abort the access with no memory update and no ready pulse.
REQ-029 Memory array contents SHALL NOT be reset; reads of never-written words return undefined data.

Verification
REQ-030 Write then read: write address 0x10, data 0xDEADBEEF, byte_enable=1111, then read 0x10 -> each ready arrives 3 cycles after capture; read_data=0xDEADBEEF, error=0.
REQ-031 Byte mask: word 0x20 holds 0x11223344; write 0xAABBCCDD with byte_enable=0101 -> subsequent read returns 0x11BB33DD.
REQ-032 Faults: read 0x13 (misaligned) and read 0x100 with DEPTH_WORDS=64 -> ready with error=1 and read_data=0; a write to 0x100 leaves all words unchanged.
REQ-033 Abort: drop request during WAIT on a write to 0x04 -> no ready pulse, and word 0x04 is unchanged on a later read.
REQ-034 Reset mid-access: reset=0 asynchronously during WAIT of a write -> ready=0 immediately, state returns to IDLE, and the target word is unchanged.
REQ-035 Zero latency: with WAIT_STATES=0, a read of 0x00 after writing 0x5 -> ready on the cycle after capture, read_data=0x00000005.
